// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Port 0 is the execute stage. Port 1 is the auxiliary address/branch-target unit.
// Grants are round-robin. A granted op sits in a one-entry issue register that
// drives the ALU, and it retires on the next edge: the result goes back to the
// issuing port, and port 0 ops also update the O/S/C/Z flag register through
// a per-opcode mask.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [OP_W-1:0]   r0_op,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [OP_W-1:0]   r1_op,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_o,
    input  logic              alu_s,
    input  logic              alu_c,
    input  logic              alu_z,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_res,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_res,
    output logic              flag_o,
    output logic              flag_s,
    output logic              flag_c,
    output logic              flag_z
);

    // Opcode encodings shared with the ALU decoder.
    localparam logic [OP_W-1:0] OP_ZEROS    = OP_W'(0);
    localparam logic [OP_W-1:0] OP_AND      = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ANDNOTA  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ANDNOTB  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_PASSA    = OP_W'(4);
    localparam logic [OP_W-1:0] OP_PASSB    = OP_W'(5);
    localparam logic [OP_W-1:0] OP_XOR      = OP_W'(6);
    localparam logic [OP_W-1:0] OP_OR       = OP_W'(7);
    localparam logic [OP_W-1:0] OP_NAND     = OP_W'(8);
    localparam logic [OP_W-1:0] OP_XNOR     = OP_W'(9);
    localparam logic [OP_W-1:0] OP_PASSNOTA = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ORNOTA   = OP_W'(11);
    localparam logic [OP_W-1:0] OP_PASSNOTB = OP_W'(12);
    localparam logic [OP_W-1:0] OP_ORNOTB   = OP_W'(13);
    localparam logic [OP_W-1:0] OP_NOR      = OP_W'(14);
    localparam logic [OP_W-1:0] OP_ONES     = OP_W'(15);
    localparam logic [OP_W-1:0] OP_ADD      = OP_W'(16);
    localparam logic [OP_W-1:0] OP_ADDINC   = OP_W'(17);
    localparam logic [OP_W-1:0] OP_INCA     = OP_W'(18);
    localparam logic [OP_W-1:0] OP_SUB      = OP_W'(19);
    localparam logic [OP_W-1:0] OP_SUBDEC   = OP_W'(20);
    localparam logic [OP_W-1:0] OP_DECA     = OP_W'(21);
    localparam logic [OP_W-1:0] OP_LSL      = OP_W'(22);
    localparam logic [OP_W-1:0] OP_ASR      = OP_W'(23);

    // Flag mask bit order: {O, S, C, Z}.
    logic              last;       // port granted most recently
    logic              iss_valid;
    logic              iss_port;
    logic [OP_W-1:0]   iss_op;
    logic [DATA_W-1:0] iss_a;
    logic [DATA_W-1:0] iss_b;
    logic [3:0]        flag_mask;

    // A port is granted when it asks and the other port either does not ask
    // or was served last. Under stall nobody is granted.
    assign r0_ready = !stall && r0_valid && (!r1_valid || last);
    assign r1_ready = !stall && r1_valid && (!r0_valid || !last);

    // The issue register drives the ALU directly.
    assign alu_op = iss_op;
    assign alu_a  = iss_a;
    assign alu_b  = iss_b;

    // Load the issue register from the granted port, or empty it when no port is granted.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of the order the always blocks run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid <= 1'b0;
            iss_port  <= 1'b0;
            iss_op    <= OP_ZEROS;
            iss_a     <= '0;
            iss_b     <= '0;
            last      <= 1'b1;
        end else if (r0_ready) begin
            iss_valid <= 1'b1;
            iss_port  <= 1'b0;
            iss_op    <= r0_op;
            iss_a     <= r0_a;
            iss_b     <= r0_b;
            last      <= 1'b0;
        end else if (r1_ready) begin
            iss_valid <= 1'b1;
            iss_port  <= 1'b1;
            iss_op    <= r1_op;
            iss_a     <= r1_a;
            iss_b     <= r1_b;
            last      <= 1'b1;
        end else begin
            iss_valid <= 1'b0;
            iss_port  <= 1'b0;
            iss_op    <= OP_ZEROS;
            iss_a     <= '0;
            iss_b     <= '0;
        end
    end

    // Decode which architectural flags the issuing opcode is allowed to write.
    // NOTE: the default assignment ahead of the case keeps unlisted opcodes
    // from inferring a latch on flag_mask.
    always_comb begin
        flag_mask = 4'b0000;
        case (iss_op)
            OP_ADD, OP_ADDINC, OP_INCA, OP_SUB, OP_SUBDEC, OP_DECA:
                flag_mask = 4'b1111;
            OP_LSL, OP_ASR:
                flag_mask = 4'b0111;
            OP_ZEROS:
                flag_mask = 4'b0001;
            OP_AND, OP_ANDNOTA, OP_ANDNOTB, OP_PASSA, OP_XOR, OP_OR, OP_NAND,
            OP_XNOR, OP_PASSNOTA, OP_ORNOTA, OP_PASSNOTB, OP_ORNOTB, OP_NOR:
                flag_mask = 4'b0101;
            default:
                flag_mask = 4'b0000;
        endcase
    end

    // Retire the issued op: pulse the owner's valid and capture its result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_res   <= '0;
            rsp1_res   <= '0;
        end else begin
            rsp0_valid <= iss_valid && !iss_port;
            rsp1_valid <= iss_valid && iss_port;
            if (iss_valid && !iss_port) begin
                rsp0_res <= alu_res;
            end
            if (iss_valid && iss_port) begin
                rsp1_res <= alu_res;
            end
        end
    end

    // Architectural flags follow port 0 retires. Bits outside the mask hold their value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_o <= 1'b0;
            flag_s <= 1'b0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (iss_valid && !iss_port) begin
            if (flag_mask[3]) flag_o <= alu_o;
            if (flag_mask[2]) flag_s <= alu_s;
            if (flag_mask[1]) flag_c <= alu_c;
            if (flag_mask[0]) flag_z <= alu_z;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter.
// It contains a combinational ALU model, a table of directed vectors,
// hand-written stall and reset sequences, and a randomized phase that is
// compared against a transaction-level reference model.
module tb_alu_arbiter;

    localparam logic [4:0] ZEROS = 5'd0,  AND_ = 5'd1,  ANDNOTA = 5'd2,  ANDNOTB = 5'd3;
    localparam logic [4:0] PASSA = 5'd4,  PASSB = 5'd5, XOR_ = 5'd6,     OR_ = 5'd7;
    localparam logic [4:0] NAND_ = 5'd8,  XNOR_ = 5'd9, PASSNOTA = 5'd10, ORNOTA = 5'd11;
    localparam logic [4:0] PASSNOTB = 5'd12, ORNOTB = 5'd13, NOR_ = 5'd14, ONES = 5'd15;
    localparam logic [4:0] ADD = 5'd16, ADDINC = 5'd17, INCA = 5'd18, SUB = 5'd19;
    localparam logic [4:0] SUBDEC = 5'd20, DECA = 5'd21, LSL = 5'd22, ASR = 5'd23;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;
    localparam logic [31:0] D0 = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        r0_valid, r1_valid;
    logic        r0_ready, r1_ready;
    logic [4:0]  r0_op, r1_op;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic [4:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_res;
    logic        alu_o, alu_s, alu_c, alu_z;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_res, rsp1_res;
    logic        flag_o, flag_s, flag_c, flag_z;

    int n_checks = 0;
    int n_errors = 0;

    alu_arbiter #(.DATA_W(32), .OP_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
        .alu_o(alu_o), .alu_s(alu_s), .alu_c(alu_c), .alu_z(alu_z),
        .rsp0_valid(rsp0_valid), .rsp0_res(rsp0_res),
        .rsp1_valid(rsp1_valid), .rsp1_res(rsp1_res),
        .flag_o(flag_o), .flag_s(flag_s), .flag_c(flag_c), .flag_z(flag_z)
    );

    always #5 clk = ~clk;

    // ALU model. The return value is packed as {O, S, C, Z, result[31:0]}.
    function automatic logic [35:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        logic [31:0] x, y, r;
        logic        cin, o, c, arith;
        arith = 1'b1; x = a; y = b; cin = 1'b0;
        case (op)
            ADD:    ;
            ADDINC: cin = 1'b1;
            INCA:   begin y = 32'h0; cin = 1'b1; end
            SUB:    begin y = ~b; cin = 1'b1; end
            SUBDEC: y = ~b;
            DECA:   y = 32'hFFFF_FFFF;
            default: arith = 1'b0;
        endcase
        sum = {1'b0, x} + {1'b0, y} + {32'h0, cin};
        r = sum[31:0];
        c = sum[32];
        o = (x[31] == y[31]) && (r[31] != x[31]);
        if (!arith) begin
            o = 1'b0;
            c = 1'b0;
            case (op)
                ZEROS:    r = 32'h0;
                AND_:     r = a & b;
                ANDNOTA:  r = ~a & b;
                ANDNOTB:  r = a & ~b;
                PASSA:    r = a;
                PASSB:    r = b;
                XOR_:     r = a ^ b;
                OR_:      r = a | b;
                NAND_:    r = ~(a & b);
                XNOR_:    r = ~(a ^ b);
                PASSNOTA: r = ~a;
                ORNOTA:   r = ~a | b;
                PASSNOTB: r = ~b;
                ORNOTB:   r = a | ~b;
                NOR_:     r = ~(a | b);
                ONES:     r = 32'hFFFF_FFFF;
                LSL:      begin r = {a[30:0], 1'b0}; c = a[31]; end
                ASR:      begin r = {a[31], a[31:1]}; c = a[0]; end
                default:  r = a ^ b ^ 32'h5A5A_0000;
            endcase
        end
        return {o, r[31], c, (r == 32'h0), r};
    endfunction

    always_comb {alu_o, alu_s, alu_c, alu_z, alu_res} = alu_fn(alu_op, alu_a, alu_b);

    // Flags each opcode may write, packed as {O, S, C, Z}.
    function automatic logic [3:0] mask_of(input logic [4:0] op);
        if (op inside {ADD, ADDINC, INCA, SUB, SUBDEC, DECA}) return 4'b1111;
        if (op inside {LSL, ASR}) return 4'b0111;
        if (op == ZEROS) return 4'b0001;
        if (op inside {AND_, ANDNOTA, ANDNOTB, PASSA, XOR_, OR_, NAND_, XNOR_,
                       PASSNOTA, ORNOTA, PASSNOTB, ORNOTB, NOR_}) return 4'b0101;
        return 4'b0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        st, v0;
        logic [4:0]  o0;
        logic [31:0] a0, b0;
        logic        v1;
        logic [4:0]  o1;
        logic [31:0] a1, b1;
        logic        e_rdy0, e_rdy1, e_v0;
        logic [31:0] e_res0;
        logic        e_v1;
        logic [31:0] e_res1;
        logic [3:0]  e_flags;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic v0, input logic [4:0] o0,
                                input logic [31:0] a0, input logic [31:0] b0,
                                input logic v1, input logic [4:0] o1,
                                input logic [31:0] a1, input logic [31:0] b1,
                                input logic e_rdy0, input logic e_rdy1,
                                input logic e_v0, input logic [31:0] e_res0,
                                input logic e_v1, input logic [31:0] e_res1,
                                input logic [3:0] e_flags);
        vec_t v;
        v.st = st; v.v0 = v0; v.o0 = o0; v.a0 = a0; v.b0 = b0;
        v.v1 = v1; v.o1 = o1; v.a1 = a1; v.b1 = b1;
        v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_v0 = e_v0; v.e_res0 = e_res0;
        v.e_v1 = e_v1; v.e_res1 = e_res1; v.e_flags = e_flags;
        return v;
    endfunction

    task automatic drive(input logic st, input logic v0, input logic [4:0] o0,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [4:0] o1,
                         input logic [31:0] a1, input logic [31:0] b1);
        stall = st;
        r0_valid = v0; r0_op = o0; r0_a = a0; r0_b = b0;
        r1_valid = v1; r1_op = o1; r1_a = a1; r1_b = b1;
    endtask

    task automatic idle();
        drive(N, N, ZEROS, D0, D0, N, ZEROS, D0, D0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Transaction-level reference model state.
    typedef struct {
        int          port;
        logic [4:0]  op;
        logic [31:0] a, b, res;
        logic [3:0]  f;
    } txn_t;

    txn_t        pipe[$];
    int          m_last;
    logic        m_v[2];
    logic [31:0] m_res[2];
    logic [3:0]  m_flags;

    vec_t vq[$];

    initial begin
        idle();
        do_reset();

        // Reset state.
        check("reset_alu_op", alu_op, ZEROS);
        check("reset_alu_a", alu_a, D0);
        check("reset_alu_b", alu_b, D0);
        check("reset_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
        check("reset_flags", {flag_o, flag_s, flag_c, flag_z}, 4'b0000);

        // Directed vectors. Expected values are sampled on the falling edge of each row's cycle.
        //          st v0 op0    a0            b0            v1 op1   a1      b1   rdy0 rdy1 v0 res0          v1 res1          flags
        vq.push_back(mk(N, Y, ADD,   32'hFFFFFFFF, 32'h1,        N, ZEROS, D0,     D0,  Y, N, N, D0,          N, D0,           4'b0000));
        vq.push_back(mk(N, N, ZEROS, D0,           D0,           N, ZEROS, D0,     D0,  N, N, N, D0,          N, D0,           4'b0000));
        vq.push_back(mk(N, N, ZEROS, D0,           D0,           N, ZEROS, D0,     D0,  N, N, Y, D0,          N, D0,           4'b0011));
        vq.push_back(mk(N, N, ZEROS, D0,           D0,           Y, PASSA, 32'h7,  D0,  N, Y, N, D0,          N, D0,           4'b0011));
        vq.push_back(mk(N, Y, INCA,  32'h1,        D0,           Y, PASSA, 32'h7,  D0,  Y, N, N, D0,          N, D0,           4'b0011));
        vq.push_back(mk(N, Y, INCA,  32'h1,        D0,           Y, PASSA, 32'h7,  D0,  N, Y, N, D0,          Y, 32'h7,        4'b0011));
        vq.push_back(mk(N, Y, INCA,  32'h1,        D0,           Y, PASSA, 32'h7,  D0,  Y, N, Y, 32'h2,       N, 32'h7,        4'b0000));
        vq.push_back(mk(N, Y, INCA,  32'h1,        D0,           Y, PASSA, 32'h7,  D0,  N, Y, N, 32'h2,       Y, 32'h7,        4'b0000));
        vq.push_back(mk(N, N, ZEROS, D0,           D0,           N, ZEROS, D0,     D0,  N, N, Y, 32'h2,       N, 32'h7,        4'b0000));
        vq.push_back(mk(N, N, ZEROS, D0,           D0,           N, ZEROS, D0,     D0,  N, N, N, 32'h2,       Y, 32'h7,        4'b0000));
        vq.push_back(mk(N, N, ZEROS, D0,           D0,           N, ZEROS, D0,     D0,  N, N, N, 32'h2,       N, 32'h7,        4'b0000));
        vq.push_back(mk(N, Y, SUB,   32'h2,        32'h2,        N, ZEROS, D0,     D0,  Y, N, N, 32'h2,       N, 32'h7,        4'b0000));
        vq.push_back(mk(N, Y, PASSB, D0,           32'h5,        N, ZEROS, D0,     D0,  Y, N, N, 32'h2,       N, 32'h7,        4'b0000));
        vq.push_back(mk(N, N, ZEROS, D0,           D0,           Y, SUB,   D0,     32'h1, N, Y, Y, D0,        N, 32'h7,        4'b0011));
        vq.push_back(mk(N, N, ZEROS, D0,           D0,           N, ZEROS, D0,     D0,  N, N, Y, 32'h5,       N, 32'h7,        4'b0011));
        vq.push_back(mk(N, N, ZEROS, D0,           D0,           N, ZEROS, D0,     D0,  N, N, N, 32'h5,       Y, 32'hFFFFFFFF, 4'b0011));
        vq.push_back(mk(N, Y, ADD,   32'h80000000, 32'h80000000, N, ZEROS, D0,     D0,  Y, N, N, 32'h5,       N, 32'hFFFFFFFF, 4'b0011));
        vq.push_back(mk(N, Y, XOR_,  32'h1,        32'h2,        N, ZEROS, D0,     D0,  Y, N, N, 32'h5,       N, 32'hFFFFFFFF, 4'b0011));
        vq.push_back(mk(N, N, ZEROS, D0,           D0,           N, ZEROS, D0,     D0,  N, N, Y, D0,          N, 32'hFFFFFFFF, 4'b1011));
        vq.push_back(mk(N, N, ZEROS, D0,           D0,           N, ZEROS, D0,     D0,  N, N, Y, 32'h3,       N, 32'hFFFFFFFF, 4'b1010));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].st, vq[i].v0, vq[i].o0, vq[i].a0, vq[i].b0,
                  vq[i].v1, vq[i].o1, vq[i].a1, vq[i].b1);
            @(negedge clk);
            check($sformatf("vec%0d_r0_ready", i), r0_ready, vq[i].e_rdy0);
            check($sformatf("vec%0d_r1_ready", i), r1_ready, vq[i].e_rdy1);
            check($sformatf("vec%0d_rsp0_valid", i), rsp0_valid, vq[i].e_v0);
            check($sformatf("vec%0d_rsp0_res", i), rsp0_res, vq[i].e_res0);
            check($sformatf("vec%0d_rsp1_valid", i), rsp1_valid, vq[i].e_v1);
            check($sformatf("vec%0d_rsp1_res", i), rsp1_res, vq[i].e_res1);
            check($sformatf("vec%0d_flags", i), {flag_o, flag_s, flag_c, flag_z}, vq[i].e_flags);
            next_cycle();
        end

        // Stall while an op is in flight. Port 0 was granted last.
        drive(N, Y, ADD, 32'hFFFFFFFF, 32'h2, N, ZEROS, D0, D0);
        @(negedge clk);
        check("stall_pre_grant0", r0_ready, Y);
        next_cycle();
        drive(Y, Y, PASSA, 32'h9, D0, Y, PASSA, 32'hA, D0);
        @(negedge clk);
        check("stall1_ready", {r0_ready, r1_ready}, 2'b00);
        check("stall1_alu_op", alu_op, ADD);
        check("stall1_alu_a", alu_a, 32'hFFFFFFFF);
        next_cycle();
        @(negedge clk);
        check("stall2_ready", {r0_ready, r1_ready}, 2'b00);
        check("stall2_rsp0_valid", rsp0_valid, Y);
        check("stall2_rsp0_res", rsp0_res, 32'h1);
        check("stall2_flags", {flag_o, flag_s, flag_c, flag_z}, 4'b0010);
        next_cycle();
        @(negedge clk);
        check("stall3_ready", {r0_ready, r1_ready}, 2'b00);
        check("stall3_rsp0_valid", rsp0_valid, N);
        check("stall3_alu_op", alu_op, ZEROS);
        next_cycle();
        stall = N;
        @(negedge clk);
        check("unstall_grant", {r0_ready, r1_ready}, 2'b01);
        next_cycle();
        idle();
        next_cycle();
        @(negedge clk);
        check("unstall_rsp1_res", rsp1_res, 32'hA);
        next_cycle();

        // Asynchronous reset between accept and retire of a port 1 ONES.
        drive(N, N, ZEROS, D0, D0, Y, ONES, D0, D0);
        @(negedge clk);
        check("rst_pre_grant1", r1_ready, Y);
        next_cycle();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
        check("rst_async_rsp0_res", rsp0_res, D0);
        check("rst_async_rsp1_res", rsp1_res, D0);
        check("rst_async_flags", {flag_o, flag_s, flag_c, flag_z}, 4'b0000);
        check("rst_async_alu_op", alu_op, ZEROS);
        check("rst_async_alu_a", alu_a, D0);
        next_cycle();
        check("rst_no_rsp1", rsp1_valid, N);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_after_no_rsp1", rsp1_valid, N);
        check("rst_after_rsp1_res", rsp1_res, D0);
        next_cycle();
        drive(N, Y, PASSA, D0, D0, Y, PASSA, D0, D0);
        @(negedge clk);
        check("rst_first_contention", {r0_ready, r1_ready}, 2'b10);
        next_cycle();

        // Randomized phase against the reference model.
        do_reset();
        pipe.delete();
        m_last = 1;
        m_v[0] = 1'b0; m_v[1] = 1'b0;
        m_res[0] = 32'h0; m_res[1] = 32'h0;
        m_flags = 4'b0000;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int          g;
            logic [31:0] d[4];
            logic [4:0]  ops[2];
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 3))
                    0: d[k] = 32'h0;
                    1: d[k] = 32'hFFFF_FFFF;
                    2: d[k] = 32'h8000_0000;
                    default: d[k] = $urandom;
                endcase
            end
            ops[0] = 5'($urandom_range(0, 31));
            ops[1] = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0), ops[0], d[0], d[1],
                  ($urandom_range(0, 2) != 0), ops[1], d[2], d[3]);

            // Grant rule: no grant under stall, a lone requester wins, and contention goes to the port not served last.
            g = -1;
            if (!stall) begin
                if (r0_valid && r1_valid) g = 1 - m_last;
                else if (r0_valid) g = 0;
                else if (r1_valid) g = 1;
            end

            @(negedge clk);
            check("rnd_r0_ready", r0_ready, (g == 0));
            check("rnd_r1_ready", r1_ready, (g == 1));
            check("rnd_rsp0_valid", rsp0_valid, m_v[0]);
            check("rnd_rsp1_valid", rsp1_valid, m_v[1]);
            check("rnd_rsp0_res", rsp0_res, m_res[0]);
            check("rnd_rsp1_res", rsp1_res, m_res[1]);
            check("rnd_flags", {flag_o, flag_s, flag_c, flag_z}, m_flags);
            if (pipe.size() > 0) begin
                check("rnd_alu_op", alu_op, pipe[0].op);
                check("rnd_alu_a", alu_a, pipe[0].a);
                check("rnd_alu_b", alu_b, pipe[0].b);
            end else begin
                check("rnd_alu_idle", {alu_op, alu_a, alu_b}, 69'h0);
            end

            @(posedge clk);
            m_v[0] = 1'b0;
            m_v[1] = 1'b0;
            if (pipe.size() > 0) begin
                txn_t t;
                logic [3:0] mk4;
                t = pipe.pop_front();
                m_v[t.port] = 1'b1;
                m_res[t.port] = t.res;
                if (t.port == 0) begin
                    mk4 = mask_of(t.op);
                    m_flags = (m_flags & ~mk4) | (t.f & mk4);
                end
            end
            if (g >= 0) begin
                txn_t n;
                logic [35:0] r;
                n.port = g;
                n.op = (g == 0) ? ops[0] : ops[1];
                n.a  = (g == 0) ? d[0] : d[2];
                n.b  = (g == 0) ? d[1] : d[3];
                r = alu_fn(n.op, n.a, n.b);
                n.res = r[31:0];
                n.f = r[35:32];
                pipe.push_back(n);
                m_last = g;
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
